accum_dbl_gather: RTL and testbench

- Operand-gathering stage directly upstream of the 108+1-input double accumulator.
- Takes one 68-bit internal-format double per cycle and packs operands into a 108-slot batch.
- Internal format: bit 64 is the exponent extension, 62:52 the exponent, 63 the sign, 51:33 and 31:0 the mantissa, bit 32 unused.
- Presents the full batch, plus the accumulator seed A, to the accumulator with a one-cycle din_en strobe.

---
 rtl/accum_pkg.sv | 40 ++++
 rtl/accum_dbl_gather_if.sv | 38 +++
 rtl/accum_gather_bank.sv | 32 +++
 rtl/accum_dbl_gather.sv | 119 +++++++++++
 tb/tb_accum_dbl_gather.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// accum_pkg
//   Shared types and constants for the double-accumulator front end.
//   dbl68_t is the 68-bit internal double format:
//     [64] exponent extension, [63] sign, [62:52] exponent,
//     [51:33] and [31:0] mantissa, [32] unused (carried through untouched).
package accum_pkg;

  typedef logic [67:0] dbl68_t;

  localparam int unsigned ACC_NSLOT = 108;

  localparam int unsigned EXP_HI  = 64;
  localparam int unsigned SGN     = 63;
  localparam int unsigned EXP_MSB = 62;
  localparam int unsigned EXP_LSB = 52;

  localparam dbl68_t DBL68_ZERO = '0;

  typedef enum logic {
    ST_EMPTY,
    ST_FILL
  } gather_state_t;

  // Full exponent field {ext, exp} is zero: denormal or zero operand.
  function automatic logic exp_is_zero(input dbl68_t x);
    return (x[EXP_HI] == 1'b0) && (x[EXP_MSB:EXP_LSB] == '0);
  endfunction

  // Flush denormals to signed zero; other values pass unchanged.
  function automatic dbl68_t daz(input dbl68_t x);
    dbl68_t r;
    r = x;
    if (exp_is_zero(x)) begin
      r      = DBL68_ZERO;
      r[SGN] = x[SGN];
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_dbl_gather_if.sv
// accum_dbl_gather_if
//   Bus between the operand source and the gather stage, plus the batch
//   handed on to the accumulator.
//   Source side : din, din_vld, din_last, flush, seed, seed_we
//   Batch side  : A (seed), B (NSLOT operands), din_en strobe
//   Status      : fill_cnt, batch_cnt
//   master = operand source, slave = accum_dbl_gather.
interface accum_dbl_gather_if
  import accum_pkg::*;
#(
  parameter int unsigned NSLOT = ACC_NSLOT,
  parameter int unsigned CW    = 7
) ();

  dbl68_t              din;
  logic                din_vld;
  logic                din_last;
  logic                flush;
  dbl68_t              seed;
  logic                seed_we;

  dbl68_t              A;
  dbl68_t [NSLOT-1:0]  B;
  logic                din_en;
  logic [CW-1:0]       fill_cnt;
  logic [15:0]         batch_cnt;

  modport master (
    output din, din_vld, din_last, flush, seed, seed_we,
    input  A, B, din_en, fill_cnt, batch_cnt
  );

  modport slave (
    input  din, din_vld, din_last, flush, seed, seed_we,
    output A, B, din_en, fill_cnt, batch_cnt
  );

endinterface

// File: rtl/accum_gather_bank.sv
// accum_gather_bank
//   NSLOT x 68 register array: one indexed write per cycle, synchronous
//   clear (wins over the write), whole array readable in parallel.
//   Ports: clk, rst (sync, active-high), clr, we, waddr, wdata, rd.
module accum_gather_bank
  import accum_pkg::*;
#(
  parameter int unsigned NSLOT = ACC_NSLOT,
  parameter int unsigned CW    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [CW-1:0]      waddr,
  input  dbl68_t             wdata,
  output dbl68_t [NSLOT-1:0] rd
);

  dbl68_t [NSLOT-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd = mem;

endmodule

// File: rtl/accum_dbl_gather.sv
// accum_dbl_gather
//   Operand-gathering stage in front of the 108+1-input double accumulator.
//   Packs one operand per cycle into an NSLOT batch and hands the batch
//   (B) plus the seed (A) over with a one-cycle din_en strobe. Accepts an
//   operand every cycle; a close in cycle t leaves the next cycle free to
//   start slot 0 of the following batch.
//   Ports: clk, rst (sync, active-high), bus (accum_dbl_gather_if.slave).
//   Build option: define ACCUM_GATHER_DAZ_EN to store operands and seeds
//   whose exponent field is zero as signed zero.
module accum_dbl_gather
  import accum_pkg::*;
#(
  parameter int unsigned NSLOT = ACC_NSLOT,
  parameter int unsigned CW    = 7
) (
  input  logic                clk,
  input  logic                rst,
  accum_dbl_gather_if.slave   bus
);

  gather_state_t       state, state_nx;
  logic [CW-1:0]       wp;
  dbl68_t              seed_r;
  logic                seed_pend;
  dbl68_t              din_w, seed_w;
  logic                close, wr_en, last_slot;
  dbl68_t [NSLOT-1:0]  bank_rd;
  dbl68_t [NSLOT-1:0]  b_nx;

`ifdef ACCUM_GATHER_DAZ_EN
  assign din_w  = daz(bus.din);
  assign seed_w = daz(bus.seed);
`else
  assign din_w  = bus.din;
  assign seed_w = bus.seed;
`endif

  assign last_slot = (wp == CW'(NSLOT - 1));

  accum_gather_bank #(
    .NSLOT (NSLOT),
    .CW    (CW)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .clr   (close),
    .we    (wr_en),
    .waddr (wp),
    .wdata (din_w),
    .rd    (bank_rd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nx;
  end

  // Next state
  always_comb begin
    state_nx = state;
    if (close)            state_nx = ST_EMPTY;
    else if (bus.din_vld) state_nx = ST_FILL;
  end

  // Outputs of the FSM: write enable and batch close
  always_comb begin
    wr_en = bus.din_vld;
    close = 1'b0;
    case (state)
      // An empty batch closes only if it gains an operand this cycle,
      // or if a pending seed makes a seed-only batch worth emitting.
      ST_EMPTY: close = (bus.din_vld && (bus.din_last || bus.flush || last_slot))
                     || (bus.flush && seed_pend);
      ST_FILL:  close = bus.flush || (bus.din_vld && (bus.din_last || last_slot));
      default:  close = 1'b0;
    endcase
  end

  // Bank slots at and beyond wp are already zero, so merging the operand
  // written this cycle gives the complete zero-padded batch.
  always_comb begin
    b_nx = bank_rd;
    if (wr_en) b_nx[wp] = din_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp            <= '0;
      bus.A         <= '0;
      bus.B         <= '0;
      bus.din_en    <= 1'b0;
      bus.batch_cnt <= '0;
      seed_r        <= '0;
      seed_pend     <= 1'b0;
    end else begin
      bus.din_en <= close;
      if (close) begin
        wp            <= '0;
        bus.A         <= seed_r;
        bus.B         <= b_nx;
        bus.batch_cnt <= bus.batch_cnt + 16'd1;
      end else if (wr_en) begin
        wp <= wp + CW'(1);
      end
      // A new seed arriving on a close is kept for the next batch.
      if (bus.seed_we) begin
        seed_r    <= seed_w;
        seed_pend <= 1'b1;
      end else if (close) begin
        seed_r    <= '0;
        seed_pend <= 1'b0;
      end
    end
  end

  assign bus.fill_cnt = wp;

endmodule

// File: tb/tb_accum_dbl_gather.sv
// tb_accum_dbl_gather
//   Directed bench for accum_dbl_gather: a per-cycle vector table plus
//   hand-written sequences for full batches, reset mid-fill and DAZ.
module tb_accum_dbl_gather;
  import accum_pkg::*;

  localparam int unsigned NS = 108;
  localparam int unsigned CWT = 7;

  // Exponent bit set so data values survive the DAZ build unchanged.
  localparam dbl68_t E   = 68'h0_4000000000000000;
  localparam dbl68_t ONE = 68'h0_3FF0000000000000;
  localparam logic   Y   = 1'b1;
  localparam logic   N   = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  accum_dbl_gather_if #(.NSLOT(NS), .CW(CWT)) bus ();

  accum_dbl_gather #(.NSLOT(NS), .CW(CWT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        vld, last, flush, we;
    dbl68_t      d, s;
    logic        en;
    logic [6:0]  fill;
    logic [15:0] bc;
    dbl68_t      a, b0, b1;
  } vec_t;

  vec_t tv [22];

  function automatic vec_t mk(input logic v, l, f, w, input dbl68_t d, s,
                              input logic en, input logic [6:0] fill,
                              input logic [15:0] bc, input dbl68_t a, b0, b1);
    vec_t r;
    r.vld = v; r.last = l; r.flush = f; r.we = w; r.d = d; r.s = s;
    r.en = en; r.fill = fill; r.bc = bc; r.a = a; r.b0 = b0; r.b1 = b1;
    return r;
  endfunction

  task automatic chk(input string nm, input dbl68_t act, input dbl68_t exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, l, f, w, input dbl68_t d, s);
    bus.din_vld = v; bus.din_last = l; bus.flush = f; bus.seed_we = w;
    bus.din = d; bus.seed = s;
    step();
    bus.din_vld = 1'b0; bus.din_last = 1'b0; bus.flush = 1'b0; bus.seed_we = 1'b0;
    bus.din = '0; bus.seed = '0;
  endtask

  // Slots below n must hold base+k, the rest +0.0.
  task automatic chk_batch(input string nm, input dbl68_t base, input int unsigned n);
    for (int unsigned k = 0; k < NS; k++) begin
      dbl68_t exp;
      exp = (k < n) ? base + 68'(k) : '0;
      chk($sformatf("%s B[%0d]", nm, k), bus.B[k], exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int unsigned spurious;
    dbl68_t exp_b, exp_a;

    bus.din_vld = 1'b0; bus.din_last = 1'b0; bus.flush = 1'b0; bus.seed_we = 1'b0;
    bus.din = '0; bus.seed = '0;

    tv[0]  = mk(N,N,N,N, '0,     '0,    N, 0, 0, '0,    '0,     '0);
    tv[1]  = mk(N,N,Y,N, '0,     '0,    N, 0, 0, '0,    '0,     '0);
    tv[2]  = mk(Y,N,N,N, E+11,   '0,    N, 1, 0, '0,    '0,     '0);
    tv[3]  = mk(Y,N,N,N, E+12,   '0,    N, 2, 0, '0,    '0,     '0);
    tv[4]  = mk(Y,N,N,N, E+13,   '0,    N, 3, 0, '0,    '0,     '0);
    tv[5]  = mk(Y,N,N,N, E+14,   '0,    N, 4, 0, '0,    '0,     '0);
    tv[6]  = mk(Y,Y,N,N, E+15,   '0,    Y, 0, 1, '0,    E+11,   E+12);
    tv[7]  = mk(Y,N,N,N, E+21,   '0,    N, 1, 1, '0,    E+11,   E+12);
    tv[8]  = mk(Y,Y,N,N, E+22,   '0,    Y, 0, 2, '0,    E+21,   E+22);
    tv[9]  = mk(Y,Y,N,N, E+31,   '0,    Y, 0, 3, '0,    E+31,   '0);
    tv[10] = mk(N,N,N,Y, '0,     ONE,   N, 0, 3, '0,    E+31,   '0);
    tv[11] = mk(Y,N,N,N, E+41,   '0,    N, 1, 3, '0,    E+31,   '0);
    tv[12] = mk(Y,N,N,N, E+42,   '0,    N, 2, 3, '0,    E+31,   '0);
    tv[13] = mk(Y,N,N,N, E+43,   '0,    N, 3, 3, '0,    E+31,   '0);
    tv[14] = mk(N,N,Y,N, '0,     '0,    Y, 0, 4, ONE,   E+41,   E+42);
    tv[15] = mk(N,N,Y,N, '0,     '0,    N, 0, 4, ONE,   E+41,   E+42);
    tv[16] = mk(N,N,N,Y, '0,     E+5,   N, 0, 4, ONE,   E+41,   E+42);
    tv[17] = mk(N,N,Y,N, '0,     '0,    Y, 0, 5, E+5,   '0,     '0);
    tv[18] = mk(Y,N,Y,N, E+51,   '0,    Y, 0, 6, '0,    E+51,   '0);
    tv[19] = mk(Y,Y,N,Y, E+61,   E+7,   Y, 0, 7, '0,    E+61,   '0);
    tv[20] = mk(Y,Y,N,N, E+62,   '0,    Y, 0, 8, E+7,   E+62,   '0);
    tv[21] = mk(Y,Y,N,N, E+63,   '0,    Y, 0, 9, '0,    E+63,   '0);

    // Reset state
    do_reset();
    chk("rst din_en",    68'(bus.din_en),    '0);
    chk("rst fill_cnt",  68'(bus.fill_cnt),  '0);
    chk("rst batch_cnt", 68'(bus.batch_cnt), '0);
    chk("rst A",         bus.A,              '0);
    chk_batch("rst", '0, 0);

    // Full batch of NS operands
    spurious = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      drive(Y, N, N, N, E + 68'(k), '0);
      if (k < NS - 1 && bus.din_en) spurious++;
      if (k == NS - 2) chk("full fill_cnt 107", 68'(bus.fill_cnt), 68'd107);
    end
    chk("full early din_en", 68'(spurious), '0);
    chk("full din_en",    68'(bus.din_en),    68'd1);
    chk("full fill_cnt",  68'(bus.fill_cnt),  '0);
    chk("full batch_cnt", 68'(bus.batch_cnt), 68'd1);
    chk("full A",         bus.A,              '0);
    chk_batch("full", E, NS);

    // Short batch closed by din_last, then slot 0 of the next batch
    for (int unsigned k = 0; k < 5; k++) drive(Y, (k == 4), N, N, E + 68'd100 + 68'(k), '0);
    chk("short din_en", 68'(bus.din_en), 68'd1);
    chk_batch("short", E + 68'd100, 5);
    drive(Y, N, N, N, E + 68'd200, '0);
    chk("next din_en",    68'(bus.din_en),    '0);
    chk("next fill_cnt",  68'(bus.fill_cnt),  68'd1);
    chk("next batch_cnt", 68'(bus.batch_cnt), 68'd2);
    drive(N, N, Y, N, '0, '0);
    chk("next flush din_en", 68'(bus.din_en), 68'd1);
    chk("next B0",           bus.B[0],        E + 68'd200);
    chk("next B1",           bus.B[1],        '0);

    // Per-cycle vector table
    do_reset();
    for (int unsigned i = 0; i < 22; i++) begin
      drive(tv[i].vld, tv[i].last, tv[i].flush, tv[i].we, tv[i].d, tv[i].s);
      chk($sformatf("row%0d din_en", i),    68'(bus.din_en),    68'(tv[i].en));
      chk($sformatf("row%0d fill_cnt", i),  68'(bus.fill_cnt),  68'(tv[i].fill));
      chk($sformatf("row%0d batch_cnt", i), 68'(bus.batch_cnt), 68'(tv[i].bc));
      chk($sformatf("row%0d A", i),         bus.A,              tv[i].a);
      chk($sformatf("row%0d B0", i),        bus.B[0],           tv[i].b0);
      chk($sformatf("row%0d B1", i),        bus.B[1],           tv[i].b1);
    end

    // Reset mid-fill discards the partial batch and the seed
    drive(N, N, N, Y, '0, E + 68'd9);
    for (int unsigned k = 0; k < 50; k++) drive(Y, N, N, N, E + 68'd500 + 68'(k), '0);
    chk("mid fill_cnt 50", 68'(bus.fill_cnt), 68'd50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst din_en",    68'(bus.din_en),    '0);
    chk("mid rst fill_cnt",  68'(bus.fill_cnt),  '0);
    chk("mid rst batch_cnt", 68'(bus.batch_cnt), '0);
    step();
    chk("mid idle din_en", 68'(bus.din_en), '0);
    spurious = 0;
    for (int unsigned k = 0; k < NS; k++) begin
      drive(Y, N, N, N, E + 68'd1000 + 68'(k), '0);
      if (k < NS - 1 && bus.din_en) spurious++;
    end
    chk("clean early din_en", 68'(spurious),      '0);
    chk("clean din_en",       68'(bus.din_en),    68'd1);
    chk("clean batch_cnt",    68'(bus.batch_cnt), 68'd1);
    chk("clean A",            bus.A,              '0);
    chk_batch("clean", E + 68'd1000, NS);

    // Zero-exponent handling and bit 32 pass-through
`ifdef ACCUM_GATHER_DAZ_EN
    exp_b = 68'h0_8000000000000000;
    exp_a = '0;
`else
    exp_b = 68'h0_800000000000ABCD;
    exp_a = 68'h0_000000000000FFFF;
`endif
    drive(Y, Y, N, N, 68'h0_800000000000ABCD, '0);
    chk("daz din_en", 68'(bus.din_en), 68'd1);
    chk("daz B0",     bus.B[0],        exp_b);
    drive(N, N, N, Y, '0, 68'h0_000000000000FFFF);
    drive(N, N, Y, N, '0, '0);
    chk("daz seed din_en", 68'(bus.din_en), 68'd1);
    chk("daz seed A",      bus.A,           exp_a);
    drive(Y, Y, N, N, E | 68'h1_0000_0000, '0);
    chk("bit32 B0", bus.B[0], E | 68'h1_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
